// File: rtl/mux_stream_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants and helpers for the mux_stream_rr stream mux.
//               Holds the mode encodings and a channel unpack function for the
//               packed multi-channel data bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Mode encodings for the mode input
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Widest packed data bus the unpack helper handles (64 channels x 64 bits)
    localparam int c_bus_w_max = 4096;

    // Returns channel idx of a packed bus in the low bits of the result.
    // The caller truncates the result to its own channel width.
    function automatic logic [c_bus_w_max-1:0] chan_slice(
        input logic [c_bus_w_max-1:0] bus,
        input int                     idx,
        input int                     w
    );
        return bus >> (idx * w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority arbiter. The search starts at
//               the channel after ptr and wraps from N-1 to 0. Produces a
//               one-hot grant and its encoded index. No grant when en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 16,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    int                w_pos;
    logic [SELW-1:0]   w_idx;
    logic              w_found;

    // Scan channels in priority order, starting just after ptr, and keep the first requester
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = SELW'(w_pos);
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_stream_rr
// Description : N-channel, W-bit valid/ready stream multiplexer with a
//               one-entry output register. Channels are chosen by direct
//               select (MODE_SEL) or round-robin arbitration (MODE_RR).
//               Optional macro MUX_LOCK_EN: packet lock in MODE_RR, holding
//               arbitration on one channel until a beat with in_last set.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_rr
    import mux_pkg::*;
#(
    parameter int W    = 16,
    parameter int N    = 16,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic            w_can_load;
    logic            w_en;
    logic            w_sel_ok;
    logic            w_xfer;
    logic [N-1:0]    w_req;
    logic [N-1:0]    w_rr_gnt;
    logic [SELW-1:0] w_rr_idx;
    logic [N-1:0]    w_gnt;
    logic [SELW-1:0] w_gnt_idx;
    logic [W-1:0]    w_gnt_data;
    logic [SELW-1:0] r_ptr;

`ifdef MUX_LOCK_EN
    logic            r_locked;
    logic [SELW-1:0] r_lock_chan;
`else
    logic            w_unused_last;
    assign w_unused_last = ^in_last;
`endif

    // Grants are suppressed during reset so no handshake can complete against a clearing register
    assign w_can_load = !out_valid || out_ready;
    assign w_en       = rst_n && w_can_load;

    // Round-robin request set; a held lock masks every other channel
    always_comb begin
`ifdef MUX_LOCK_EN
        w_req = r_locked ? (in_valid & (N'(1) << r_lock_chan)) : in_valid;
`else
        w_req = in_valid;
`endif
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .en      (w_en && (mode == MODE_RR)),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    // Direct select looks only at the selected channel; out-of-range selects never grant
    assign w_sel_ok = w_en && (mode == MODE_SEL) && (32'(sel) < N) && in_valid[sel];

    // Final grant from whichever mode is active
    always_comb begin
        if (mode == MODE_SEL) begin
            w_gnt     = w_sel_ok ? (N'(1) << sel) : '0;
            w_gnt_idx = sel;
        end else begin
            w_gnt     = w_rr_gnt;
            w_gnt_idx = w_rr_idx;
        end
    end

    assign in_ready   = w_gnt;
    assign w_xfer     = |w_gnt;
    assign w_gnt_data = W'(chan_slice(c_bus_w_max'(in_data), int'(w_gnt_idx), W));

    // Output register: load on a handshake, otherwise empty once the consumer takes the beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (w_xfer) begin
            out_valid <= 1'b1;
            out_data  <= w_gnt_data;
            out_chan  <= w_gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer (and packet lock) advance only on MODE_RR handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= SELW'(N - 1);
`ifdef MUX_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_chan <= '0;
`endif
        end else if ((mode == MODE_RR) && w_xfer) begin
`ifdef MUX_LOCK_EN
            if (in_last[w_gnt_idx]) begin
                r_locked <= 1'b0;
                r_ptr    <= w_gnt_idx;
            end else begin
                r_locked    <= 1'b1;
                r_lock_chan <= w_gnt_idx;
            end
`else
            r_ptr <= w_gnt_idx;
`endif
        end
`ifdef MUX_LOCK_EN
        else if (mode == MODE_SEL) begin
            r_locked <= 1'b0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_stream_rr
// Description : Directed self-checking bench for mux_stream_rr (16x16 main
//               instance plus a 17-channel instance for select range limits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream_rr;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [3:0]    sel;
    logic [255:0]  in_data;
    logic [15:0]   in_valid;
    logic [15:0]   in_last;
    logic [15:0]   in_ready;
    logic [15:0]   out_data;
    logic [3:0]    out_chan;
    logic          out_valid;
    logic          out_ready;

    logic          mode17;
    logic [4:0]    sel17;
    logic [135:0]  in_data17;
    logic [16:0]   in_valid17;
    logic [16:0]   in_last17;
    logic [16:0]   in_ready17;
    logic [7:0]    out_data17;
    logic [4:0]    out_chan17;
    logic          out_valid17;
    logic          out_ready17;

    int total;
    int bad;

    mux_stream_rr #(.W(16), .N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_stream_rr #(.W(8), .N(17)) dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode17),
        .sel       (sel17),
        .in_data   (in_data17),
        .in_valid  (in_valid17),
        .in_last   (in_last17),
        .in_ready  (in_ready17),
        .out_data  (out_data17),
        .out_chan  (out_chan17),
        .out_valid (out_valid17),
        .out_ready (out_ready17)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    // Channel i carries base+i
    task automatic fill_data(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            in_data[i*16 +: 16] = base + 16'(i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '0; in_last = '1;
        out_ready = 1'b1; fill_data(16'h1000);
        mode17 = 1'b0; sel17 = '0; in_data17 = '0; in_valid17 = '0;
        in_last17 = '1; out_ready17 = 1'b1;
        #12;
        rst_n = 1'b1;
        in_valid = 16'hFFFF;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h want=0000", out_data); end
        total++;
        if (out_chan !== 4'd0) begin bad++; $display("FAIL rst_out_chan got=%0d want=0", out_chan); end
        total++;
        if (in_ready !== 16'h0000) begin bad++; $display("FAIL rst_in_ready got=%h want=0000", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_held_valid got=%0b want=0", out_valid); end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 16'h0001) begin bad++; $display("FAIL rst_first_ready got=%h want=0001", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd0 || out_valid !== 1'b1 || out_data !== 16'h1000) begin
            bad++; $display("FAIL rst_first_beat got=chan%0d v%0b %h want=chan0 v1 1000", out_chan, out_valid, out_data);
        end
    endtask

    task automatic test_sel();
        mode = 1'b0; sel = 4'd5; in_valid = 16'h0020; in_data[5*16 +: 16] = 16'hA5A5;
        #1;
        total++;
        if (in_ready !== 16'h0020) begin bad++; $display("FAIL sel_ready got=%h want=0020", in_ready); end
        step();
        total++;
        if (out_data !== 16'hA5A5 || out_chan !== 4'd5 || out_valid !== 1'b1) begin
            bad++; $display("FAIL sel_beat got=chan%0d v%0b %h want=chan5 v1 a5a5", out_chan, out_valid, out_data);
        end
        in_valid = 16'hFFDF;
        #1;
        total++;
        if (in_ready !== 16'h0000) begin bad++; $display("FAIL sel_invalid_ready got=%h want=0000", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL sel_drain got=%0b want=0", out_valid); end
        in_valid = '0;
        // 17-channel instance: select beyond the last channel never grants
        in_data17[16*8 +: 8] = 8'h5C;
        sel17 = 5'd17; in_valid17 = '1;
        #1;
        total++;
        if (in_ready17 !== 17'h00000) begin bad++; $display("FAIL sel17_oor_ready got=%h want=00000", in_ready17); end
        step();
        total++;
        if (out_valid17 !== 1'b0) begin bad++; $display("FAIL sel17_oor_valid got=%0b want=0", out_valid17); end
        sel17 = 5'd16;
        #1;
        total++;
        if (in_ready17 !== 17'h10000) begin bad++; $display("FAIL sel17_top_ready got=%h want=10000", in_ready17); end
        step();
        total++;
        if (out_chan17 !== 5'd16 || out_data17 !== 8'h5C || out_valid17 !== 1'b1) begin
            bad++; $display("FAIL sel17_top_beat got=chan%0d v%0b %h want=chan16 v1 5c", out_chan17, out_valid17, out_data17);
        end
        in_valid17 = '0;
    endtask

    task automatic test_rr_fair();
        pulse_reset();
        fill_data(16'h1000);
        mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (out_chan !== 4'(k % 16) || out_valid !== 1'b1) begin
                bad++; $display("FAIL rr_chan_%0d got=chan%0d v%0b want=chan%0d v1", k, out_chan, out_valid, k % 16);
            end
            total++;
            if (out_data !== 16'h1000 + 16'(k % 16)) begin
                bad++; $display("FAIL rr_data_%0d got=%h want=%h", k, out_data, 16'h1000 + 16'(k % 16));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 16'h0000) begin bad++; $display("FAIL bp_ready got=%h want=0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_chan !== 4'd3 || out_data !== 16'h1003 || out_valid !== 1'b1 || in_ready !== 16'h0000) begin
                bad++; $display("FAIL bp_hold_%0d got=chan%0d %h v%0b rdy%h want=chan3 1003 v1 rdy0000",
                                k, out_chan, out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 16'h0010) begin bad++; $display("FAIL bp_release_ready got=%h want=0010", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd4 || out_valid !== 1'b1 || out_data !== 16'h1004) begin
            bad++; $display("FAIL bp_reload got=chan%0d v%0b %h want=chan4 v1 1004", out_chan, out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'd0; exp_seq[1] = 4'd1; exp_seq[2] = 4'd0;
        in_valid = 16'h4000;
        step();
        total++;
        if (out_chan !== 4'd14) begin bad++; $display("FAIL wrap_setup got=%0d want=14", out_chan); end
        in_valid = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_chan !== exp_seq[k] || out_valid !== 1'b1) begin
                bad++; $display("FAIL wrap_%0d got=chan%0d v%0b want=chan%0d v1", k, out_chan, out_valid, exp_seq[k]);
            end
        end
        in_valid = 16'h0000;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_drain got=%0b want=0", out_valid); end
        in_valid = 16'h0003;
        #1;
        total++;
        if (in_ready !== 16'h0002) begin bad++; $display("FAIL idle_ptr_kept got=%h want=0002", in_ready); end
        step();
        mode = 1'b0; sel = 4'd0;
        #1;
        total++;
        if (in_ready !== 16'h0001) begin bad++; $display("FAIL mode_sel_ready got=%h want=0001", in_ready); end
        step();
        mode = 1'b1;
        #1;
        total++;
        if (in_ready !== 16'h0001) begin bad++; $display("FAIL ptr_retained got=%h want=0001", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL ptr_retained_beat got=chan%0d v%0b want=chan0 v1", out_chan, out_valid);
        end
        in_valid = '0;
    endtask

`ifdef MUX_LOCK_EN
    task automatic test_lock();
        pulse_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 16'h0018; in_last = 16'hFFF7;
        #1;
        total++;
        if (in_ready !== 16'h0008) begin bad++; $display("FAIL lock_first_ready got=%h want=0008", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd3) begin bad++; $display("FAIL lock_beat0 got=%0d want=3", out_chan); end
        total++;
        if (in_ready !== 16'h0008) begin bad++; $display("FAIL lock_held_ready got=%h want=0008", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd3) begin bad++; $display("FAIL lock_beat1 got=%0d want=3", out_chan); end
        in_valid = 16'h0010;
        #1;
        total++;
        if (in_ready !== 16'h0000) begin bad++; $display("FAIL lock_gap_ready got=%h want=0000", in_ready); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL lock_gap_valid got=%0b want=0", out_valid); end
        in_valid = 16'h0018; in_last = 16'hFFFF;
        #1;
        total++;
        if (in_ready !== 16'h0008) begin bad++; $display("FAIL lock_last_ready got=%h want=0008", in_ready); end
        step();
        total++;
        if (out_chan !== 4'd3 || out_valid !== 1'b1) begin
            bad++; $display("FAIL lock_beat2 got=chan%0d v%0b want=chan3 v1", out_chan, out_valid);
        end
        step();
        total++;
        if (out_chan !== 4'd4 || out_valid !== 1'b1) begin
            bad++; $display("FAIL lock_release got=chan%0d v%0b want=chan4 v1", out_chan, out_valid);
        end
        in_valid = '0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sel();
        test_rr_fair();
        test_backpressure();
        test_wrap();
`ifdef MUX_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
